// File: rtl/branch_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_fwd_ctrl_pkg
// Shared definitions for the ID-stage branch forwarding/hazard controller:
// register address width, the hard-wired zero register, the shadow slot
// record tracking one in-flight destination register, and the match helper.
// ---------------------------------------------------------------------------
package branch_fwd_ctrl_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One shadow pipeline slot: does the instruction in this stage write a
    // register, and which one.
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] waddr;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{v: 1'b0, waddr: REG_ZERO};

    // Register 0 is constant, so it is never a forwarding or stall source.
    function automatic logic slot_match(input slot_t s, input logic [ADDR_W-1:0] r);
        return s.v && (s.waddr == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/branch_fwd_ctrl_fwd_match_unit.sv
// ---------------------------------------------------------------------------
// fwd_match_unit
// Per-operand decision for one branch compare operand.
//   need_i      operand is actually read by a valid branch in ID
//   reg_i       source register of the operand
//   ex_slot_i   shadow slot for EX
//   mem_slot_i  shadow slot for MEM
//   wb_slot_i   shadow slot for WB
//   hazard_o    producer still in EX or MEM: ID must stall
//   fwd_o       producer in WB: take the write-back value
// ---------------------------------------------------------------------------
module fwd_match_unit
    import branch_fwd_ctrl_pkg::*;
(
    input  logic              need_i,
    input  logic [ADDR_W-1:0] reg_i,
    input  slot_t             ex_slot_i,
    input  slot_t             mem_slot_i,
    input  slot_t             wb_slot_i,
    output logic              hazard_o,
    output logic              fwd_o
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = slot_match(ex_slot_i,  reg_i);
    assign hit_mem = slot_match(mem_slot_i, reg_i);
    assign hit_wb  = slot_match(wb_slot_i,  reg_i);

    // A younger producer in EX/MEM overrides an older one in WB, so the
    // forward path is only taken when no hazard exists.
    assign hazard_o = need_i & (hit_ex | hit_mem);
    assign fwd_o    = need_i & ~hazard_o & hit_wb;

endmodule

// File: rtl/branch_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// branch_fwd_ctrl
// Hazard/forwarding controller for the ID-stage branch compare operands.
// Tracks destination registers of the instructions in EX, MEM and WB and
// either selects the WB write-back value for an operand or stalls ID until
// the producer reaches WB. Also counts stall cycles and issued branches.
//   clk, rst                 clock, asynchronous active-high reset
//   id_*                     decoded fields of the instruction held in ID
//   pipe_hold                global freeze: slots and counters hold
//   flush                    squash EX and MEM
//   control_rdata_a/b        1 = operand takes mem_wb_dout
//   stall_id                 hold PC and IF/ID, bubble into ID/EX
//   stall_cycles             cycles with stall_id set (wraps)
//   branch_count             branches issued from ID (wraps)
// ---------------------------------------------------------------------------
module branch_fwd_ctrl
    import branch_fwd_ctrl_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wreg,
    input  logic [AW-1:0]    id_waddr,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             control_rdata_a,
    output logic             control_rdata_b,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] branch_count
);

    slot_t ex_q,  ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q,  wb_d;

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;

    logic need_a;
    logic need_b;
    logic hazard_a;
    logic hazard_b;
    logic fwd_a;
    logic fwd_b;

    assign need_a = id_valid & id_is_branch & id_uses_rs;
    assign need_b = id_valid & id_is_branch & id_uses_rt;

    fwd_match_unit u_match_a (
        .need_i     (need_a),
        .reg_i      (id_rs),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .wb_slot_i  (wb_q),
        .hazard_o   (hazard_a),
        .fwd_o      (fwd_a)
    );

    fwd_match_unit u_match_b (
        .need_i     (need_b),
        .reg_i      (id_rt),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .wb_slot_i  (wb_q),
        .hazard_o   (hazard_b),
        .fwd_o      (fwd_b)
    );

    assign stall_id        = hazard_a | hazard_b;
    assign control_rdata_a = fwd_a;
    assign control_rdata_b = fwd_b;
    assign stall_cycles    = stall_cycles_q;
    assign branch_count    = branch_count_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block leaves it unassigned, which would infer a latch.
        ex_d           = ex_q;
        mem_d          = mem_q;
        wb_d           = wb_q;
        stall_cycles_d = stall_cycles_q;
        branch_count_d = branch_count_q;

        if (!pipe_hold) begin
            wb_d        = mem_q;
            mem_d       = ex_q;
            // A stalled ID sends a bubble, not its instruction, into EX.
            ex_d.v      = id_valid & id_wreg & ~stall_id;
            ex_d.waddr  = id_waddr;

            // Flush kills whatever would land in EX and MEM; WB still retires.
            if (flush) begin
                ex_d.v  = 1'b0;
                mem_d.v = 1'b0;
            end

            if (stall_id) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (id_valid && id_is_branch && !stall_id) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q           <= SLOT_EMPTY;
            mem_q          <= SLOT_EMPTY;
            wb_q           <= SLOT_EMPTY;
            stall_cycles_q <= '0;
            branch_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_cycles_q <= stall_cycles_d;
            branch_count_q <= branch_count_d;
        end
    end

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_fwd_ctrl
// Directed bench for branch_fwd_ctrl. A reference model tracks in-flight
// register writes as a list of producers with an age (0 = EX, 1 = MEM,
// 2 = WB) and derives the outputs from the youngest matching producer.
// ---------------------------------------------------------------------------
module tb_branch_fwd_ctrl;

    localparam int AW    = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic             id_is_branch;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_wreg;
    logic [AW-1:0]    id_waddr;
    logic             pipe_hold;
    logic             flush;
    logic             control_rdata_a;
    logic             control_rdata_b;
    logic             stall_id;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] branch_count;

    always #5 clk = ~clk;

    branch_fwd_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_wreg         (id_wreg),
        .id_waddr        (id_waddr),
        .pipe_hold       (pipe_hold),
        .flush           (flush),
        .control_rdata_a (control_rdata_a),
        .control_rdata_b (control_rdata_b),
        .stall_id        (stall_id),
        .stall_cycles    (stall_cycles),
        .branch_count    (branch_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        int addr;
        int age;
    } prod_t;

    prod_t prods[$];
    prod_t nq[$];
    int    m_stalls;
    int    m_branches;
    bit    m_st;

    function automatic int youngest(input int r);
        int best = -1;
        foreach (prods[i])
            if (prods[i].addr == r && (best < 0 || prods[i].age < best))
                best = prods[i].age;
        return best;
    endfunction

    function automatic bit m_hazard(input bit need, input int r);
        int y;
        if (!need || r == 0) return 1'b0;
        y = youngest(r);
        return (y == 0) || (y == 1);
    endfunction

    function automatic bit m_fwd(input bit need, input int r);
        if (!need || r == 0) return 1'b0;
        return youngest(r) == 2;
    endfunction

    function automatic bit need_a_m();
        return id_valid && id_is_branch && id_uses_rs;
    endfunction

    function automatic bit need_b_m();
        return id_valid && id_is_branch && id_uses_rt;
    endfunction

    function automatic bit m_stall();
        return m_hazard(need_a_m(), int'(id_rs)) || m_hazard(need_b_m(), int'(id_rt));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prods.delete();
            m_stalls   = 0;
            m_branches = 0;
        end else if (!pipe_hold) begin
            m_st = m_stall();
            if (m_st) m_stalls++;
            if (id_valid && id_is_branch && !m_st) m_branches++;
            nq.delete();
            // Producers age by one stage; flush kills the one leaving EX,
            // and anything leaving WB is gone.
            foreach (prods[i])
                if (prods[i].age < 2 && !(flush && prods[i].age == 0))
                    nq.push_back('{prods[i].addr, prods[i].age + 1});
            if (!flush && id_valid && id_wreg && !m_st)
                nq.push_back('{int'(id_waddr), 0});
            prods = nq;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cmp_stall_id", stall_id, m_stall());
            check("cmp_rdata_a", control_rdata_a, m_fwd(need_a_m(), int'(id_rs)));
            check("cmp_rdata_b", control_rdata_b, m_fwd(need_b_m(), int'(id_rt)));
            check("cmp_stall_cycles", stall_cycles, m_stalls);
            check("cmp_branch_count", branch_count, m_branches);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic idle_inputs();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_wreg      = 1'b0;
        id_waddr     = '0;
    endtask

    task automatic nop(input int n);
        idle_inputs();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic alu(input int wa);
        idle_inputs();
        id_valid = 1'b1;
        id_wreg  = 1'b1;
        id_waddr = AW'(wa);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_branch(input int rs, input int rt, input bit ur, input bit ut);
        idle_inputs();
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        id_rs        = AW'(rs);
        id_rt        = AW'(rt);
        id_uses_rs   = ur;
        id_uses_rt   = ut;
    endtask

    // Holds the branch in ID until it issues; reports stall length and the
    // operand selects seen in the issue cycle.
    task automatic branch(input int rs, input int rt, input bit ur, input bit ut,
                          output int ns, output logic fa, output logic fb);
        bit done = 1'b0;
        set_branch(rs, rt, ur, ut);
        ns = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall_id) begin
                done = 1'b1;
                break;
            end
            ns++;
            @(posedge clk);
            #1;
        end
        if (!done) check("branch_issue_timeout", 32'd0, 32'd1);
        fa = control_rdata_a;
        fb = control_rdata_b;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   ns;
        int   high;
        logic fa, fb;
        logic [CNT_W-1:0] sc0;

        rst       = 1'b1;
        pipe_hold = 1'b0;
        flush     = 1'b0;
        idle_inputs();
        #12;
        check("reset_stall_id", stall_id, 1'b0);
        check("reset_rdata_a", control_rdata_a, 1'b0);
        check("reset_rdata_b", control_rdata_b, 1'b0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_branch_count", branch_count, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // 1) producer one ahead of the branch: two stall cycles, then WB forward
        alu(3);
        branch(3, 4, 1'b1, 1'b1, ns, fa, fb);
        check("t1_stall_len", ns, 2);
        check("t1_rdata_a", fa, 1'b1);
        check("t1_rdata_b", fb, 1'b0);
        check("t1_stall_cycles", stall_cycles, 32'd2);
        check("t1_branch_count", branch_count, 32'd1);
        nop(3);

        // 2) producer two ahead: one stall; r0 operand never forwards
        alu(5);
        nop(1);
        branch(0, 5, 1'b1, 1'b1, ns, fa, fb);
        check("t2_stall_len", ns, 1);
        check("t2_rdata_a", fa, 1'b0);
        check("t2_rdata_b", fb, 1'b1);
        check("t2_stall_cycles", stall_cycles, 32'd3);
        nop(3);

        // 3) both operands depend on the same producer
        alu(7);
        branch(7, 7, 1'b1, 1'b1, ns, fa, fb);
        check("t3_stall_len", ns, 2);
        check("t3_rdata_a", fa, 1'b1);
        check("t3_rdata_b", fb, 1'b1);
        check("t3_branch_count", branch_count, 32'd3);
        nop(3);

        // 4) freeze for three cycles in the middle of a stall
        alu(3);
        set_branch(3, 2, 1'b1, 1'b1);
        sc0  = stall_cycles;
        high = 0;
        #1;
        if (stall_id) high++;
        @(posedge clk);
        #1;
        pipe_hold = 1'b1;
        repeat (3) begin
            #1;
            if (stall_id) high++;
            @(posedge clk);
            #1;
        end
        pipe_hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!stall_id) break;
            high++;
            @(posedge clk);
            #1;
        end
        check("t4_stall_high", high, 5);
        check("t4_stall_delta", stall_cycles - sc0, 32'd2);
        check("t4_rdata_a", control_rdata_a, 1'b1);
        @(posedge clk);
        #1;
        idle_inputs();
        check("t4_branch_count", branch_count, 32'd4);
        nop(3);

        // 5) flush squashes the producer in EX
        alu(9);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        branch(9, 1, 1'b1, 1'b1, ns, fa, fb);
        check("t5_stall_len", ns, 0);
        check("t5_rdata_a", fa, 1'b0);
        nop(3);

        // r0 as destination never creates a dependency
        alu(0);
        branch(0, 0, 1'b1, 1'b1, ns, fa, fb);
        check("r0_stall_len", ns, 0);
        check("r0_rdata_a", fa, 1'b0);
        nop(3);

        // younger producer in EX beats an older one in WB
        alu(6);
        nop(1);
        alu(6);
        branch(6, 6, 1'b1, 1'b0, ns, fa, fb);
        check("young_stall_len", ns, 2);
        check("young_rdata_a", fa, 1'b1);
        check("young_rdata_b", fb, 1'b0);
        nop(3);

        // non-branch readers never stall here
        alu(4);
        id_valid   = 1'b1;
        id_uses_rs = 1'b1;
        id_rs      = AW'(4);
        #1;
        check("nonbranch_stall", stall_id, 1'b0);
        @(posedge clk);
        #1;
        nop(3);

        // 6) asynchronous reset during a stall
        alu(3);
        set_branch(3, 4, 1'b1, 1'b1);
        #1;
        check("t6_pre_stall", stall_id, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_stall", stall_id, 1'b0);
        check("t6_rst_rdata_a", control_rdata_a, 1'b0);
        check("t6_rst_rdata_b", control_rdata_b, 1'b0);
        check("t6_rst_stall_cycles", stall_cycles, 32'd0);
        check("t6_rst_branch_count", branch_count, 32'd0);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        branch(3, 4, 1'b1, 1'b1, ns, fa, fb);
        check("t6_post_stall_len", ns, 0);
        check("t6_post_rdata_a", fa, 1'b0);
        check("t6_post_branch_count", branch_count, 32'd1);
        check("t6_post_stall_cycles", stall_cycles, 32'd0);
        nop(2);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
